shader_zresolve: RTL and testbench

- Downstream of the Z-grouping/shader stage.
- Collects one candidate colour per Z layer for a single pixel. The beats arrive in layer order 0..ZLAYERS-1, one per accepted cycle, matching the interleaved layer pipeline.
- Resolves visibility: layer 0 is frontmost; the first opaque layer wins, otherwise the background colour is used.
- Presents the resolved pixel on a valid/ready output port to the scanout/framebuffer writer.

---
 rtl/leopard_pkg.sv | 33 +++
 rtl/shader_zresolve.sv | 151 +++++++++++++++
 tb/tb_shader_zresolve.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/leopard_pkg.sv
// Shared types for the Z-resolve stage: layer grouping, FSM states and the
// beat/pixel record layouts at the default widths.
package leopard_pkg;

    localparam int ZLAYERS_PER_GROUP = 5;

    localparam int DEF_ZGROUPS      = 1;
    localparam int DEF_ZLAYERS      = DEF_ZGROUPS * ZLAYERS_PER_GROUP;
    localparam int DEF_LAYER_W      = $clog2(DEF_ZLAYERS);
    localparam int DEF_SHADERS_POW2 = 3;
    localparam int DEF_COLOR_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OUTPUT  = 2'd2
    } resolve_state_t;

    typedef struct packed {
        logic [DEF_LAYER_W-1:0]      layer;
        logic                        opaque;
        logic [DEF_SHADERS_POW2-1:0] shader;
        logic [DEF_COLOR_W-1:0]      color;
    } layer_beat_t;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0]      color;
        logic                        hit;
        logic [DEF_LAYER_W-1:0]      layer;
        logic [DEF_SHADERS_POW2-1:0] shader;
    } pixel_out_t;

endpackage

// File: rtl/shader_zresolve.sv
// Per-pixel Z-layer visibility resolve. Collects one beat per layer in
// front-to-back order, keeps the first opaque beat as the winner and
// presents the resolved pixel (or the background) on a valid/ready port.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | ready=1, waiting for strobe; latches bg_color on strobe
// ST_COLLECT | in_ready=1, consuming exactly ZLAYERS beats
// ST_OUTPUT  | pix_valid=1, resolved pixel held until pix_ready
module shader_zresolve
    import leopard_pkg::*;
#(
    parameter int ZGROUPS      = 1,
    parameter int SHADERS_POW2 = 3,
    parameter int COLOR_W      = 16
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic                             strobe,
    output logic                             ready,
    input  logic [COLOR_W-1:0]               bg_color,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [$clog2(ZGROUPS*5)-1:0]     in_layer,
    input  logic                             in_opaque,
    input  logic [SHADERS_POW2-1:0]          in_shader,
    input  logic [COLOR_W-1:0]               in_color,
    output logic                             pix_valid,
    input  logic                             pix_ready,
    output logic [COLOR_W-1:0]               pix_color,
    output logic                             pix_hit,
    output logic [$clog2(ZGROUPS*5)-1:0]     pix_layer,
    output logic [SHADERS_POW2-1:0]          pix_shader,
    output logic                             seq_err
);

    localparam int ZLAYERS = ZGROUPS * ZLAYERS_PER_GROUP;
    localparam int LAYER_W = $clog2(ZLAYERS);
    localparam int K_W     = $clog2(ZLAYERS + 1);

    resolve_state_t          state;
    logic [K_W-1:0]          k;
    logic [COLOR_W-1:0]      bg_q;
    logic                    hit;
    logic [COLOR_W-1:0]      win_color;
    logic [SHADERS_POW2-1:0] win_shader;
    logic [LAYER_W-1:0]      win_layer;

    logic                    beat_take;
    logic                    beat_wins;
    logic                    last_beat;
    logic                    hit_nxt;
    logic [COLOR_W-1:0]      win_color_nxt;
    logic [SHADERS_POW2-1:0] win_shader_nxt;
    logic [LAYER_W-1:0]      win_layer_nxt;

    // Winner view including the beat being accepted this cycle, so the last
    // beat can still win when the pixel is handed to the output registers.
    always_comb begin
        beat_take      = in_valid && in_ready;
        beat_wins      = beat_take && !hit && in_opaque;
        last_beat      = beat_take && (k == K_W'(ZLAYERS - 1));
        hit_nxt        = hit;
        win_color_nxt  = win_color;
        win_shader_nxt = win_shader;
        win_layer_nxt  = win_layer;
        if (beat_wins) begin
            hit_nxt        = 1'b1;
            win_color_nxt  = in_color;
            win_shader_nxt = in_shader;
            win_layer_nxt  = LAYER_W'(k);
        end
    end

    // Resolve FSM with registered handshake and pixel outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= ST_IDLE;
            ready      <= 1'b1;
            in_ready   <= 1'b0;
            pix_valid  <= 1'b0;
            pix_color  <= '0;
            pix_hit    <= 1'b0;
            pix_layer  <= '0;
            pix_shader <= '0;
            seq_err    <= 1'b0;
            k          <= '0;
            bg_q       <= '0;
            hit        <= 1'b0;
            win_color  <= '0;
            win_shader <= '0;
            win_layer  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (strobe) begin
                        bg_q       <= bg_color;
                        k          <= '0;
                        hit        <= 1'b0;
                        win_color  <= '0;
                        win_shader <= '0;
                        win_layer  <= '0;
                        ready      <= 1'b0;
                        in_ready   <= 1'b1;
                        state      <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (beat_take) begin
                        // Order errors are flagged only; resolution follows beat order.
                        if (K_W'(in_layer) != k) begin
                            seq_err <= 1'b1;
                        end
                        hit        <= hit_nxt;
                        win_color  <= win_color_nxt;
                        win_shader <= win_shader_nxt;
                        win_layer  <= win_layer_nxt;
                        k          <= k + 1'b1;
                        if (last_beat) begin
                            in_ready   <= 1'b0;
                            pix_valid  <= 1'b1;
                            pix_hit    <= hit_nxt;
                            pix_color  <= hit_nxt ? win_color_nxt : bg_q;
                            pix_layer  <= hit_nxt ? win_layer_nxt : '0;
                            pix_shader <= hit_nxt ? win_shader_nxt : '0;
                            state      <= ST_OUTPUT;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (pix_ready) begin
                        pix_valid  <= 1'b0;
                        pix_color  <= '0;
                        pix_hit    <= 1'b0;
                        pix_layer  <= '0;
                        pix_shader <= '0;
                        ready      <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ready    <= 1'b1;
                    in_ready <= 1'b0;
                    pix_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shader_zresolve.sv
// Bench for shader_zresolve: expected pixels are computed from the beat list
// (first opaque beat in order wins), queued at stimulus time and compared
// when the DUT hands the pixel over.
module tb_shader_zresolve;

    localparam int ZL = 5;
    localparam int LW = 3;
    localparam int SW = 3;
    localparam int CW = 16;

    typedef struct packed {
        logic [CW-1:0] color;
        logic          hit;
        logic [LW-1:0] layer;
        logic [SW-1:0] shader;
    } exp_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic          strobe;
    logic          ready;
    logic [CW-1:0] bg_color;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_layer;
    logic          in_opaque;
    logic [SW-1:0] in_shader;
    logic [CW-1:0] in_color;
    logic          pix_valid;
    logic          pix_ready;
    logic [CW-1:0] pix_color;
    logic          pix_hit;
    logic [LW-1:0] pix_layer;
    logic [SW-1:0] pix_shader;
    logic          seq_err;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb[$];
    logic exp_seq = 1'b0;

    logic [CW-1:0] b_col[ZL];
    logic [SW-1:0] b_shd[ZL];
    logic [LW-1:0] b_lay[ZL];
    logic          b_opq[ZL];

    shader_zresolve #(.ZGROUPS(1), .SHADERS_POW2(SW), .COLOR_W(CW)) dut (
        .aclk(aclk), .areset(areset), .strobe(strobe), .ready(ready),
        .bg_color(bg_color), .in_valid(in_valid), .in_ready(in_ready),
        .in_layer(in_layer), .in_opaque(in_opaque), .in_shader(in_shader),
        .in_color(in_color), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_color(pix_color), .pix_hit(pix_hit), .pix_layer(pix_layer),
        .pix_shader(pix_shader), .seq_err(seq_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare at the negedge before each output handshake.
    always @(negedge aclk) begin
        if (!areset && pix_valid && pix_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pixel", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pix_color",  32'(pix_color),  32'(e.color));
                chk("pix_hit",    32'(pix_hit),    32'(e.hit));
                chk("pix_layer",  32'(pix_layer),  32'(e.layer));
                chk("pix_shader", 32'(pix_shader), 32'(e.shader));
            end
        end
    end

    task automatic set_beats(input logic [4:0] opq, input logic [CW-1:0] c0, input logic [CW-1:0] step);
        for (int j = 0; j < ZL; j++) begin
            b_opq[j] = opq[j];
            b_col[j] = c0 + CW'(j) * step;
            b_shd[j] = SW'(j + 1);
            b_lay[j] = LW'(j);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge aclk);
        while (!ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!ready) chk("timeout_ready", 32'(ready), 32'd1);
    endtask

    task automatic do_strobe(input logic [CW-1:0] bg);
        wait_ready();
        strobe   = 1'b1;
        bg_color = bg;
        @(posedge aclk); #1;
        strobe   = 1'b0;
        bg_color = 16'hDEAD;
    endtask

    // Drive beat j, optionally after idle gap cycles, and wait for acceptance.
    task automatic send_beat(input int j, input int gap);
        int n = 0;
        for (int g = 0; g < gap; g++) begin
            @(posedge aclk); #1;
        end
        in_valid  = 1'b1;
        in_layer  = b_lay[j];
        in_opaque = b_opq[j];
        in_shader = b_shd[j];
        in_color  = b_col[j];
        @(negedge aclk);
        while (!in_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!in_ready) chk("timeout_in_ready", 32'(in_ready), 32'd1);
        @(posedge aclk); #1;
        in_valid = 1'b0;
        if (b_lay[j] != LW'(j)) exp_seq = 1'b1;
        chk("seq_err", 32'(seq_err), 32'(exp_seq));
    endtask

    task automatic push_expected(input logic [CW-1:0] bg);
        exp_t e;
        e = '{color: bg, hit: 1'b0, layer: '0, shader: '0};
        for (int j = ZL - 1; j >= 0; j--) begin
            if (b_opq[j]) e = '{color: b_col[j], hit: 1'b1, layer: LW'(j), shader: b_shd[j]};
        end
        sb.push_back(e);
    endtask

    // One full pixel; hold>0 keeps pix_ready low that many cycles and pokes strobe.
    task automatic run_pixel(input logic [CW-1:0] bg, input int gap, input int hold);
        logic [CW-1:0] snap_c;
        logic [LW-1:0] snap_l;
        pix_ready = (hold == 0);
        do_strobe(bg);
        push_expected(bg);
        for (int j = 0; j < ZL; j++) send_beat(j, gap);
        @(negedge aclk);
        chk("latency_pix_valid", 32'(pix_valid), 32'd1);
        if (hold > 0) begin
            snap_c = pix_color;
            snap_l = pix_layer;
            strobe = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge aclk);
                chk("hold_valid",    32'(pix_valid), 32'd1);
                chk("hold_color",    32'(pix_color), 32'(snap_c));
                chk("hold_layer",    32'(pix_layer), 32'(snap_l));
                chk("hold_ready",    32'(ready),     32'd0);
                chk("hold_in_ready", 32'(in_ready),  32'd0);
            end
            strobe = 1'b0;
            @(posedge aclk); #1;
            pix_ready = 1'b1;
        end
        @(posedge aclk); #1;
        chk("ready_after_hs", 32'(ready), 32'd1);
        chk("pix_valid_after_hs", 32'(pix_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1; strobe = 1'b0; bg_color = '0; in_valid = 1'b0;
        in_layer = '0; in_opaque = 1'b0; in_shader = '0; in_color = '0;
        pix_ready = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk("rst_ready",     32'(ready),     32'd1);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_color", 32'(pix_color), 32'd0);
        chk("rst_seq_err",   32'(seq_err),   32'd0);

        // in_valid in IDLE must not be consumed
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            chk("idle_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge aclk); #1 in_valid = 1'b0;

        // single winner at layer 2
        set_beats(5'b01100, 16'h1111, 16'h1111);
        run_pixel(16'h0000, 0, 0);

        // all transparent -> background
        set_beats(5'b00000, 16'h1111, 16'h1111);
        run_pixel(16'hF81F, 0, 0);

        // backpressure with strobe poked during OUTPUT
        set_beats(5'b01100, 16'h1111, 16'h1111);
        run_pixel(16'h0000, 0, 7);
        @(negedge aclk);
        chk("strobe_in_output_ignored", 32'(ready), 32'd1);
        @(negedge aclk);
        chk("strobe_in_output_idle", 32'(in_ready), 32'd0);

        // gapped beats give the same result
        set_beats(5'b01100, 16'h1111, 16'h1111);
        run_pixel(16'h0000, 2, 0);

        // layer 0 opaque wins over later opaque layers
        set_beats(5'b11111, 16'h1000, 16'h0101);
        b_col[0] = 16'hABCD;
        b_shd[0] = 3'd5;
        run_pixel(16'h0F0F, 0, 0);

        // last layer only
        set_beats(5'b10000, 16'h0001, 16'h0202);
        run_pixel(16'h7777, 1, 0);

        // sequence error 0,1,3,3,4
        set_beats(5'b01010, 16'h0A0A, 16'h1010);
        b_lay[2] = 3'd3;
        run_pixel(16'h0000, 0, 0);
        set_beats(5'b00100, 16'h2000, 16'h0001);
        run_pixel(16'h0000, 0, 0);
        chk("seq_err_sticky", 32'(seq_err), 32'd1);

        // reset mid-COLLECT after 2 beats
        set_beats(5'b00001, 16'h3000, 16'h0001);
        do_strobe(16'h1234);
        send_beat(0, 0);
        send_beat(1, 0);
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        exp_seq = 1'b0;
        @(negedge aclk);
        chk("mid_rst_ready",     32'(ready),     32'd1);
        chk("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("mid_rst_seq_err",   32'(seq_err),   32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd0);

        // fresh pixel after the abandoned one
        set_beats(5'b01000, 16'h4321, 16'h0011);
        run_pixel(16'h5555, 0, 0);

        repeat (3) @(posedge aclk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
